// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the ID-stage control path: opcodes, functs, ALU codes,
// pc_sel / MemtoReg encodings, FSM states and the registered control bundle.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_UART_RX = 6'h06;
   localparam logic [5:0] OP_UART_TX = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd5;
   localparam logic [3:0] ALU_OR  = 4'd6;
   localparam logic [3:0] ALU_SLL = 4'd8;
   localparam logic [3:0] ALU_LUI = 4'd11;
   localparam logic [3:0] ALU_SLT = 4'd12;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   typedef enum logic [1:0] {PC_PLUS4, PC_JUMP, PC_JR, PC_BRANCH} pc_sel_e;
   typedef enum logic [1:0] {MR_ALU, MR_MEM, MR_PC4, MR_UART} mem_to_reg_e;
   typedef enum logic {S_RUN, S_MULT} state_e;

   typedef struct packed {
      logic        valid;
      logic [1:0]  reg_dst;
      logic [3:0]  alu_ctrl;
      logic        alu_src_b;
      mem_to_reg_e mem_to_reg;
      logic        uart_sel;
      logic        mem_write;
      logic        reg_write;
      logic        mult_op;
      logic        mflo;
   } ctrl_bundle_t;

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// ID-stage bus: IF/ID instruction fields and EX hazard info in, ID/EX control
// bundle plus PC steering out. slave = decoder, master = its driver.
interface decode_ctrl_pipe_if #(
   parameter int ALUCTRL_W  = 4,
   parameter int REG_ADDR_W = 5
);
   logic                  instr_valid;
   logic [5:0]            opcode;
   logic [5:0]            funct;
   logic [REG_ADDR_W-1:0] rs;
   logic [REG_ADDR_W-1:0] rt;
   logic                  zero;
   logic [REG_ADDR_W-1:0] ex_rt;
   logic                  ex_lw;

   logic                  ctrl_valid;
   logic [1:0]            RegDst;
   logic [ALUCTRL_W-1:0]  ALUControl;
   logic                  ALUSrcB;
   logic [1:0]            MemtoReg;
   logic                  uart_sel;
   logic                  MemWrite;
   logic                  RegWrite;
   logic                  mult_op;
   logic                  mflo;
   logic [1:0]            pc_sel;
   logic                  PC_En;
   logic                  flush_ifid;
   logic                  illegal_op;

   modport slave (
      input  instr_valid, opcode, funct, rs, rt, zero, ex_rt, ex_lw,
      output ctrl_valid, RegDst, ALUControl, ALUSrcB, MemtoReg, uart_sel,
             MemWrite, RegWrite, mult_op, mflo, pc_sel, PC_En, flush_ifid, illegal_op
   );

   modport master (
      output instr_valid, opcode, funct, rs, rt, zero, ex_rt, ex_lw,
      input  ctrl_valid, RegDst, ALUControl, ALUSrcB, MemtoReg, uart_sel,
             MemWrite, RegWrite, mult_op, mflo, pc_sel, PC_En, flush_ifid, illegal_op
   );
endinterface

// File: rtl/mult_busy_tracker.sv
// Down-counter started on mult issue; busy until LO is valid. clear is a
// synchronous wipe that discards any count in flight.
module mult_busy_tracker #(
   parameter int MULT_CYCLES = 4
) (
   input  logic clk,
   input  logic clear,
   input  logic start,
   output logic busy
);
   localparam int CNT_W = 4;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (start)
         count <= CNT_W'(MULT_CYCLES - 1);
      else if (count != '0)
         count <= count - CNT_W'(1);
   end

   assign busy = (count != '0);
endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered ID-stage decoder with stall/flush/mult tracking and sticky illegal flag.
// Build option: DECODE_LOADUSE_STALL_EN enables the one-cycle load-use interlock.
//
//   state  | meaning
//   S_RUN  | no multiply in flight
//   S_MULT | multiply in flight; mflo/mult stall until the counter drains
module decode_ctrl_pipe
   import mips_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W   = 4,
   parameter int REG_ADDR_W  = 5,
   parameter int MULT_CYCLES = 4
) (
   input logic          clk,
   input logic          reset,
   decode_ctrl_pipe_if.slave bus
);
   ctrl_bundle_t dec, ctrl_q;
   logic         legal, rt_src, is_mult, is_mflo, is_j, is_jr, is_beq, is_bne;
   logic         load_use, mult_stall, stall, issue, mult_issue, mult_busy, illegal_q;
   logic         ex_dst_live, rs_hit, rt_hit;
   pc_sel_e      pc_sel_c;
   state_e       state_q, state_d;

   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      legal     = 1'b1;
      rt_src    = 1'b0;
      is_mult   = 1'b0;
      is_mflo   = 1'b0;
      is_j      = 1'b0;
      is_jr     = 1'b0;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      case (bus.opcode)
         OP_RTYPE: begin
            rt_src = 1'b1;
            case (bus.funct)
               FN_SLL:  begin dec.reg_dst = RD_RD; dec.alu_ctrl = ALU_SLL; dec.reg_write = 1'b1; end
               FN_JR:   is_jr = 1'b1;
               FN_MFLO: begin dec.reg_dst = RD_RD; dec.mflo = 1'b1; dec.reg_write = 1'b1; is_mflo = 1'b1; end
               FN_MULT: begin dec.mult_op = 1'b1; is_mult = 1'b1; end
               FN_ADD:  begin dec.reg_dst = RD_RD; dec.alu_ctrl = ALU_ADD; dec.reg_write = 1'b1; end
               FN_OR:   begin dec.reg_dst = RD_RD; dec.alu_ctrl = ALU_OR;  dec.reg_write = 1'b1; end
               FN_SLT:  begin dec.reg_dst = RD_RD; dec.alu_ctrl = ALU_SLT; dec.reg_write = 1'b1; end
               default: legal = 1'b0;
            endcase
         end
         OP_J:       is_j = 1'b1;
         OP_JAL:     begin is_j = 1'b1; dec.reg_dst = RD_RA; dec.mem_to_reg = MR_PC4; dec.reg_write = 1'b1; end
         OP_BEQ:     begin is_beq = 1'b1; rt_src = 1'b1; dec.alu_ctrl = ALU_SUB; end
         OP_BNE:     begin is_bne = 1'b1; rt_src = 1'b1; dec.alu_ctrl = ALU_SUB; end
         OP_UART_RX: begin dec.mem_to_reg = MR_UART; dec.reg_write = 1'b1; end
         OP_UART_TX: begin dec.mem_to_reg = MR_UART; dec.uart_sel = 1'b1; dec.reg_write = 1'b1; end
         OP_ADDI:    begin dec.alu_ctrl = ALU_ADD; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; end
         OP_SLTI:    begin dec.alu_ctrl = ALU_SLT; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; end
         OP_ANDI:    begin dec.alu_ctrl = ALU_AND; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; end
         OP_ORI:     begin dec.alu_ctrl = ALU_OR;  dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; end
         OP_LUI:     begin dec.alu_ctrl = ALU_LUI; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; end
         OP_LW:      begin dec.alu_ctrl = ALU_ADD; dec.alu_src_b = 1'b1; dec.mem_to_reg = MR_MEM; dec.reg_write = 1'b1; end
         OP_SW:      begin rt_src = 1'b1; dec.alu_ctrl = ALU_ADD; dec.alu_src_b = 1'b1; dec.mem_write = 1'b1; end
         default:    legal = 1'b0;
      endcase
   end

   // A load targeting $0 never creates a real dependency.
   assign ex_dst_live = bus.ex_lw && (bus.ex_rt != REG_ADDR_W'(0));
   assign rs_hit      = (bus.ex_rt == bus.rs);
   assign rt_hit      = (bus.ex_rt == bus.rt);

`ifdef DECODE_LOADUSE_STALL_EN
   assign load_use = bus.instr_valid && ex_dst_live && (rs_hit || (rt_src && rt_hit));
`else
   logic unused_loaduse;
   assign load_use       = 1'b0;
   assign unused_loaduse = ^{ex_dst_live, rs_hit, rt_hit, rt_src};
`endif

   assign mult_stall = bus.instr_valid && (is_mult || is_mflo) && (state_q == S_MULT) && mult_busy;
   assign stall      = load_use || mult_stall;
   assign issue      = bus.instr_valid && legal && !stall;
   assign mult_issue = issue && is_mult;

   mult_busy_tracker #(.MULT_CYCLES(MULT_CYCLES)) u_mult_busy (
      .clk   (clk),
      .clear (!reset),
      .start (mult_issue),
      .busy  (mult_busy)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (mult_issue) state_d = S_MULT;
         S_MULT:  if (!mult_issue && !mult_busy) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      pc_sel_c = PC_PLUS4;
      if (issue) begin
         if (is_j)                          pc_sel_c = PC_JUMP;
         else if (is_jr)                    pc_sel_c = PC_JR;
         else if (is_beq && bus.zero)       pc_sel_c = PC_BRANCH;
         else if (is_bne && !bus.zero)      pc_sel_c = PC_BRANCH;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_RUN;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= issue ? dec : '0;
         if (bus.instr_valid && !legal)
            illegal_q <= 1'b1;
      end
   end

   assign bus.ctrl_valid = ctrl_q.valid;
   assign bus.RegDst     = ctrl_q.reg_dst;
   assign bus.ALUControl = ALUCTRL_W'(ctrl_q.alu_ctrl);
   assign bus.ALUSrcB    = ctrl_q.alu_src_b;
   assign bus.MemtoReg   = ctrl_q.mem_to_reg;
   assign bus.uart_sel   = ctrl_q.uart_sel;
   assign bus.MemWrite   = ctrl_q.mem_write;
   assign bus.RegWrite   = ctrl_q.reg_write;
   assign bus.mult_op    = ctrl_q.mult_op;
   assign bus.mflo       = ctrl_q.mflo;
   assign bus.pc_sel     = pc_sel_c;
   assign bus.PC_En      = !stall;
   assign bus.flush_ifid = (pc_sel_c != PC_PLUS4);
   assign bus.illegal_op = illegal_q;
endmodule
